// File: rtl/brick_draw.sv
// brick_draw: rasterises one brick rectangle to the VGA adapter write port.
//
// A start pulse seen in idle latches the brick's top-left pixel and health,
// then one pixel per cycle is presented in raster order (x fastest) for
// exactly BRICK_W*BRICK_H cycles, followed by a one-cycle done pulse.
// Pixels that fall off the right or bottom of the screen still take their
// cycle but are not plotted. Health 0 paints black, erasing the brick.
//
// Ports:
//   clk        system clock
//   resetn     synchronous, active-low reset
//   start      one-cycle draw request, honoured only while idle
//   x_in       brick top-left x pixel (10 bits)
//   y_in       brick top-left y pixel (10 bits)
//   health_in  brick health 0..3
//   busy       high whenever a brick is being drawn or completing
//   done       one-cycle pulse after the last pixel
//   vga_x      current pixel x (0 outside drawing)
//   vga_y      current pixel y (0 outside drawing)
//   colour     current pixel colour {R,G,B} (0 outside drawing)
//   plot       VGA write enable
//
// state  | meaning
// S_IDLE | waiting for start
// S_DRAW | presenting one pixel per cycle
// S_DONE | done pulse, then back to idle
module brick_draw #(
    parameter int BRICK_W = 8,
    parameter int BRICK_H = 4,
    parameter int X_MAX   = 160,
    parameter int Y_MAX   = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    input  logic [1:0] health_in,
    output logic       busy,
    output logic       done,
    output logic [9:0] vga_x,
    output logic [9:0] vga_y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] OX_LAST = 6'(BRICK_W - 1);
    localparam logic [5:0] OY_LAST = 6'(BRICK_H - 1);

    logic [1:0]  state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [1:0]  health_q, health_d;
    logic [5:0]  ox_q, ox_d;
    logic [5:0]  oy_q, oy_d;

    logic        last_col;
    logic        last_pix;
    logic [10:0] x_sum;
    logic [10:0] y_sum;

    assign last_col = (ox_q == OX_LAST);
    assign last_pix = last_col && (oy_q == OY_LAST);

    // Sums are one bit wider than the coordinates so that a brick placed
    // near 1023 is seen as off-screen rather than wrapping back to x=0.
    assign x_sum = {1'b0, x_q} + {5'b0, ox_q};
    assign y_sum = {1'b0, y_q} + {5'b0, oy_q};

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = start ? S_DRAW : S_IDLE;
            S_DRAW:  state_d = last_pix ? S_DONE : S_DRAW;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latched brick and raster offsets
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        health_d = health_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        if (state_q == S_IDLE && start) begin
            x_d      = x_in;
            y_d      = y_in;
            health_d = health_in;
            ox_d     = '0;
            oy_d     = '0;
        end else if (state_q == S_DRAW) begin
            if (last_col) begin
                ox_d = '0;
                oy_d = oy_q + 6'd1;
            end else begin
                ox_d = ox_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            health_q <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            health_q <= health_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
        end
    end

    // Outputs
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        plot   = 1'b0;
        vga_x  = '0;
        vga_y  = '0;
        colour = '0;
        if (state_q == S_DRAW) begin
            vga_x = x_sum[9:0];
            vga_y = y_sum[9:0];
            plot  = (x_sum < 11'(X_MAX)) && (y_sum < 11'(Y_MAX));
            case (health_q)
                2'd3:    colour = 3'b100;
                2'd2:    colour = 3'b110;
                2'd1:    colour = 3'b010;
                default: colour = 3'b000;
            endcase
        end
    end

endmodule

// File: tb/tb_brick_draw.sv
module tb_brick_draw;

    localparam int BW = 8;
    localparam int BH = 4;
    localparam int XM = 160;
    localparam int YM = 120;
    localparam int NPIX = BW * BH;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [9:0] x_in;
    logic [9:0] y_in;
    logic [1:0] health_in;
    logic       busy;
    logic       done;
    logic [9:0] vga_x;
    logic [9:0] vga_y;
    logic [2:0] colour;
    logic       plot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    brick_draw #(.BRICK_W(BW), .BRICK_H(BH), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .health_in (health_in),
        .busy      (busy),
        .done      (done),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .colour    (colour),
        .plot      (plot)
    );

    function automatic logic [2:0] ref_colour(input int h);
        case (h)
            3:       return 3'b100;
            2:       return 3'b110;
            1:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Draws one brick and checks every pixel against the reference rectangle.
    // Called at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle following done. disturb_at >= 0 scrambles the inputs and
    // pulses start during that pixel; start_in_done pulses start in the done
    // cycle. Both must be ignored.
    task automatic run_brick(input string name, input int x, input int y, input int h,
                             input int disturb_at, input bit start_in_done,
                             output int plots);
        int ex, ey;
        bit exp_plot;
        logic [2:0] exp_col;
        plots = 0;
        exp_col = ref_colour(h);
        x_in = 10'(x); y_in = 10'(y); health_in = 2'(h);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clk);
            start = 1'b0;
            ex = x + (i % BW);
            ey = y + (i / BW);
            exp_plot = (ex < XM) && (ey < YM);
            n_checks++;
            if (plot !== exp_plot || vga_x !== 10'(ex) || vga_y !== 10'(ey) ||
                colour !== exp_col || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s pixel %0d: got plot=%b x=%0d y=%0d col=%b busy=%b done=%b, want plot=%b x=%0d y=%0d col=%b busy=1 done=0",
                         name, i, plot, vga_x, vga_y, colour, busy, done,
                         exp_plot, 10'(ex), 10'(ey), exp_col);
            end
            if (plot === 1'b1) plots++;
            if (i == disturb_at) begin
                x_in = 10'($urandom_range(0, 1023));
                y_in = 10'($urandom_range(0, 1023));
                health_in = 2'(h + 1);
                start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || plot !== 1'b0 || vga_x !== 10'd0 ||
            vga_y !== 10'd0 || colour !== 3'd0) begin
            n_fail++;
            $display("FAIL %s done cycle: got done=%b busy=%b plot=%b x=%0d y=%0d col=%b, want done=1 busy=1 plot=0 x=0 y=0 col=0",
                     name, done, busy, plot, vga_x, vga_y, colour);
        end
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after done: got busy=%b done=%b plot=%b, want 0 0 0",
                     name, busy, done, plot);
        end
        n_checks++;
        if (plots != ((x < XM ? ((XM - x) < BW ? (XM - x) : BW) : 0) *
                      (y < YM ? ((YM - y) < BH ? (YM - y) : BH) : 0))) begin
            n_fail++;
            $display("FAIL %s plot count: got %0d, want rectangle/screen overlap", name, plots);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; x_in = '0; y_in = '0; health_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0 || vga_x !== 10'd0 ||
            vga_y !== 10'd0 || colour !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: got busy=%b done=%b plot=%b x=%0d y=%0d col=%b, want all 0",
                     busy, done, plot, vga_x, vga_y, colour);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after reset: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int p;
        run_brick("basic", 8, 4, 3, -1, 1'b0, p);
        n_checks++;
        if (p != 32) begin
            n_fail++;
            $display("FAIL basic plots: got %0d want 32", p);
        end
    endtask

    task automatic test_clipping();
        int p;
        run_brick("right_edge", 156, 0, 1, -1, 1'b0, p);
        n_checks++;
        if (p != 16) begin n_fail++; $display("FAIL right_edge plots: got %0d want 16", p); end
        run_brick("bottom_edge", 0, 118, 2, -1, 1'b0, p);
        n_checks++;
        if (p != 16) begin n_fail++; $display("FAIL bottom_edge plots: got %0d want 16", p); end
        run_brick("wrap_1020", 1020, 10, 3, -1, 1'b0, p);
        n_checks++;
        if (p != 0) begin n_fail++; $display("FAIL wrap_1020 plots: got %0d want 0", p); end
    endtask

    task automatic test_back_to_back();
        int p;
        run_brick("busy_start", 0, 0, 2, 12, 1'b1, p);
        // The done-cycle start must not have launched a draw.
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_start_ignored: got busy=%b want 0", busy);
        end
        run_brick("erase", 40, 20, 0, -1, 1'b0, p);
        // Earliest follow-on: start in the idle cycle right after done.
        run_brick("follow_on", 100, 50, 1, -1, 1'b0, p);
    endtask

    task automatic test_reset_mid_draw();
        int p;
        x_in = 10'd30; y_in = 10'd30; health_in = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        n_checks++;
        if (plot !== 1'b1 || vga_x !== 10'd31 || vga_y !== 10'd31) begin
            n_fail++;
            $display("FAIL pre_reset pixel 9: got plot=%b x=%0d y=%0d want 1 31 31", plot, vga_x, vga_y);
        end
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || vga_x !== 10'd0 ||
            vga_y !== 10'd0 || colour !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got plot=%b busy=%b done=%b x=%0d y=%0d col=%b want all 0",
                     plot, busy, done, vga_x, vga_y, colour);
        end
        resetn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL no_done_after_reset cycle %0d: got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        run_brick("after_reset", 64, 60, 2, -1, 1'b0, p);
    endtask

    task automatic test_random();
        int p, rx, ry, rh;
        for (int k = 0; k < 8; k++) begin
            rx = (k % 2 == 0) ? int'($urandom_range(0, 170)) : int'($urandom_range(0, 1023));
            ry = int'($urandom_range(0, 125));
            rh = int'($urandom_range(0, 3));
            run_brick("random", rx, ry, rh, int'($urandom_range(0, NPIX + 5)), 1'(k % 2), p);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clipping();
        test_back_to_back();
        test_reset_mid_draw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
